// File: rtl/dds_ctrl_parser_if.sv
// Byte-stream input and DDS configuration outputs of the command-frame parser.
`timescale 1ns/1ps
interface dds_ctrl_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  wave_sel_out;
  logic [31:0] ftw_out;
  logic        cfg_update;
  logic        frame_err;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  wave_sel_out, ftw_out, cfg_update, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wave_sel_out, ftw_out, cfg_update, frame_err, busy
  );
endinterface

// File: rtl/dds_ctrl_parser.sv
// Decodes 7-byte checksummed command frames into DDS waveform select and tuning word.
`timescale 1ns/1ps
module dds_ctrl_parser #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  dds_ctrl_parser_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_D3, S_D2, S_D1, S_D0, S_CHK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       cmd_q,   cmd_d;
  logic [31:0]      pay_q,   pay_d;
  logic [7:0]       chk_q,   chk_d;
  logic [2:0]       wave_q,  wave_d;
  logic [31:0]      ftw_q,   ftw_d;
  logic             upd_q,   upd_d;
  logic             err_q,   err_d;
  logic             busy_q,  busy_d;
  logic             cmd_ok_c;
  logic             chk_ok_c;

  // Command legality is judged on the captured CMD/payload when CHK arrives.
  assign cmd_ok_c = ((cmd_q == 8'h01) && (pay_q[2:0] <= 3'd4)) ||
                    (cmd_q == 8'h02) || (cmd_q == 8'h03);
  assign chk_ok_c = (bus.rx_data == chk_q);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      pay_q   <= '0;
      chk_q   <= '0;
      wave_q  <= '0;
      ftw_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      pay_q   <= pay_d;
      chk_q   <= chk_d;
      wave_q  <= wave_d;
      ftw_q   <= ftw_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    pay_d   = pay_q;
    chk_d   = chk_q;
    wave_d  = wave_q;
    ftw_d   = ftw_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;

    // An arriving byte always beats the timeout in the same cycle.
    if (bus.rx_valid) begin
      cnt_d = '0;
      unique case (state_q)
        S_IDLE: if (bus.rx_data == HDR_BYTE) state_d = S_CMD;
        S_CMD: begin
          cmd_d   = bus.rx_data;
          chk_d   = bus.rx_data;
          state_d = S_D3;
        end
        S_D3, S_D2, S_D1, S_D0: begin
          pay_d   = {pay_q[23:0], bus.rx_data};
          chk_d   = chk_q ^ bus.rx_data;
          state_d = state_e'(state_q + 3'd1);
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (chk_ok_c && cmd_ok_c) begin
            upd_d = 1'b1;
            unique case (cmd_q)
              8'h01:   wave_d = pay_q[2:0];
              8'h02:   ftw_d  = pay_q;
              default: begin
                wave_d = '0;
                ftw_d  = '0;
              end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LIMIT) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.wave_sel_out = wave_q;
  assign bus.ftw_out      = ftw_q;
  assign bus.cfg_update   = upd_q;
  assign bus.frame_err    = err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_dds_ctrl_parser.sv
// Scoreboard bench for dds_ctrl_parser: frames, errors, timeout, reset.
`timescale 1ns/1ps
module tb_dds_ctrl_parser;

  typedef struct packed {
    logic        upd;
    logic        err;
    logic [2:0]  wave;
    logic [31:0] ftw;
  } exp_t;

  logic Clk;
  logic Rst_n;
  dds_ctrl_parser_if bus();

  dds_ctrl_parser #(.TIMEOUT_CYC(16), .HDR_BYTE(8'hA5)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.slave)
  );

  int          tests_run = 0;
  int          fails     = 0;
  exp_t        exp_q[$];
  logic [2:0]  m_wave = '0;
  logic [31:0] m_ftw  = '0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", tests_run, fails);
    $fatal(1, "watchdog");
  end

  // Every output pulse must match the next expected event in the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (bus.cfg_update === 1'b1 || bus.frame_err === 1'b1) begin
        tests_run++;
        if (bus.cfg_update === 1'b1 && bus.frame_err === 1'b1) begin
          fails++;
          $display("FAIL pulse_overlap: cfg_update=%b frame_err=%b, required not both", bus.cfg_update, bus.frame_err);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: cfg_update=%b frame_err=%b, required no pulse", bus.cfg_update, bus.frame_err);
        end else begin
          e = exp_q.pop_front();
          if ({bus.cfg_update, bus.frame_err, bus.wave_sel_out, bus.ftw_out} !== e) begin
            fails++;
            $display("FAIL scoreboard: got upd=%b err=%b wave=%0d ftw=%h, required upd=%b err=%b wave=%0d ftw=%h",
                     bus.cfg_update, bus.frame_err, bus.wave_sel_out, bus.ftw_out, e.upd, e.err, e.wave, e.ftw);
          end
        end
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge Clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Predicts the frame outcome from the frame bytes, then drives it back-to-back.
  task automatic send_frame(input logic [55:0] f);
    logic [7:0]  cmd, chk, calc;
    logic [31:0] p;
    logic        ok;
    cmd  = f[47:40];
    p    = f[39:8];
    chk  = f[7:0];
    calc = cmd ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    ok   = (calc == chk) &&
           (((cmd == 8'h01) && (p[2:0] <= 3'd4)) || (cmd == 8'h02) || (cmd == 8'h03));
    if (ok) begin
      if (cmd == 8'h01) m_wave = p[2:0];
      else if (cmd == 8'h02) m_ftw = p;
      else begin
        m_wave = '0;
        m_ftw  = '0;
      end
    end
    exp_q.push_back({ok, !ok, m_wave, m_ftw});
    for (int i = 6; i >= 0; i--) drive(f[8*i +: 8]);
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    idle(3);
    tests_run++;
    if ({bus.wave_sel_out, bus.ftw_out, bus.cfg_update, bus.frame_err, bus.busy} !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs: wave=%0d ftw=%h upd=%b err=%b busy=%b, required all 0",
               bus.wave_sel_out, bus.ftw_out, bus.cfg_update, bus.frame_err, bus.busy);
    end
    Rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_ftw;
    send_frame(56'hA5_02_00_01_00_00_03);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.ftw_out !== 32'h00010000 || bus.wave_sel_out !== 3'd0) begin
      fails++;
      $display("FAIL ftw_commit: upd=%b ftw=%h wave=%0d, required upd=1 ftw=00010000 wave=0",
               bus.cfg_update, bus.ftw_out, bus.wave_sel_out);
    end
    idle(1);
    tests_run++;
    if (bus.cfg_update !== 1'b0) begin
      fails++;
      $display("FAIL ftw_pulse_width: upd=%b one cycle later, required 0", bus.cfg_update);
    end
  endtask

  task automatic test_wave;
    send_frame(56'hA5_01_00_00_00_03_02);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.wave_sel_out !== 3'd3) begin
      fails++;
      $display("FAIL wave_commit: upd=%b wave=%0d, required upd=1 wave=3", bus.cfg_update, bus.wave_sel_out);
    end
    idle(2);
    send_frame(56'hA5_01_00_00_00_07_06);
    tests_run++;
    if (bus.frame_err !== 1'b1 || bus.cfg_update !== 1'b0 || bus.wave_sel_out !== 3'd3) begin
      fails++;
      $display("FAIL wave_illegal: err=%b upd=%b wave=%0d, required err=1 upd=0 wave=3",
               bus.frame_err, bus.cfg_update, bus.wave_sel_out);
    end
    idle(2);
  endtask

  task automatic test_bad_chk;
    send_frame(56'hA5_02_12_34_56_78_00);
    tests_run++;
    if (bus.frame_err !== 1'b1 || bus.ftw_out !== 32'h00010000 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL bad_chk: err=%b ftw=%h busy=%b, required err=1 ftw=00010000 busy=0",
               bus.frame_err, bus.ftw_out, bus.busy);
    end
    idle(2);
  endtask

  task automatic test_timeout;
    int hit;
    hit = 0;
    exp_q.push_back({1'b0, 1'b1, m_wave, m_ftw});
    drive(8'hA5);
    drive(8'h02);
    drive(8'h11);
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk);
      #1;
      if (bus.frame_err === 1'b1) begin
        hit = k;
        break;
      end
    end
    tests_run++;
    if (hit != 16) begin
      fails++;
      $display("FAIL timeout_latency: frame_err after %0d cycles, required 16", hit);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle: busy=%b, required 0", bus.busy);
    end
    idle(1);
    send_frame(56'hA5_02_CA_FE_00_01_37);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.ftw_out !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL after_timeout: upd=%b ftw=%h, required upd=1 ftw=cafe0001", bus.cfg_update, bus.ftw_out);
    end
    idle(2);
  endtask

  // A byte arriving in the very cycle the counter hits its limit keeps the frame alive.
  task automatic test_timeout_boundary;
    m_ftw = 32'h00000042;
    exp_q.push_back({1'b1, 1'b0, m_wave, m_ftw});
    drive(8'hA5);
    idle(15);
    drive(8'h02);
    idle(15);
    drive(8'h00);
    drive(8'h00);
    drive(8'h00);
    drive(8'h42);
    drive(8'h40);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.ftw_out !== 32'h00000042) begin
      fails++;
      $display("FAIL timeout_boundary: upd=%b ftw=%h, required upd=1 ftw=00000042", bus.cfg_update, bus.ftw_out);
    end
    idle(2);
  endtask

  task automatic test_garbage;
    drive(8'h00);
    drive(8'hFF);
    drive(8'h5A);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL garbage_ignored: busy=%b err=%b, required busy=0 err=0", bus.busy, bus.frame_err);
    end
    send_frame(56'hA5_02_00_00_12_34_24);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.ftw_out !== 32'h00001234) begin
      fails++;
      $display("FAIL garbage_frame: upd=%b ftw=%h, required upd=1 ftw=00001234", bus.cfg_update, bus.ftw_out);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    send_frame(56'hA5_01_00_00_00_04_05);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.wave_sel_out !== 3'd4) begin
      fails++;
      $display("FAIL b2b_first: upd=%b wave=%0d, required upd=1 wave=4", bus.cfg_update, bus.wave_sel_out);
    end
    send_frame(56'hA5_02_00_00_00_10_12);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.ftw_out !== 32'h00000010 || bus.wave_sel_out !== 3'd4) begin
      fails++;
      $display("FAIL b2b_second: upd=%b ftw=%h wave=%0d, required upd=1 ftw=00000010 wave=4",
               bus.cfg_update, bus.ftw_out, bus.wave_sel_out);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    send_frame(56'hA5_02_DE_AD_BE_EF_20);
    tests_run++;
    if (bus.ftw_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL deadbeef_commit: ftw=%h, required deadbeef", bus.ftw_out);
    end
    idle(1);
    drive(8'hA5);
    drive(8'h02);
    drive(8'hDE);
    Rst_n  = 1'b0;
    m_wave = '0;
    m_ftw  = '0;
    #1;
    tests_run++;
    if ({bus.wave_sel_out, bus.ftw_out, bus.cfg_update, bus.frame_err, bus.busy} !== 38'd0) begin
      fails++;
      $display("FAIL reset_mid_frame: wave=%0d ftw=%h upd=%b err=%b busy=%b, required all 0",
               bus.wave_sel_out, bus.ftw_out, bus.cfg_update, bus.frame_err, bus.busy);
    end
    idle(2);
    Rst_n = 1'b1;
    idle(1);
    send_frame(56'hA5_03_00_00_00_00_03);
    tests_run++;
    if (bus.cfg_update !== 1'b1 || bus.ftw_out !== 32'd0 || bus.wave_sel_out !== 3'd0) begin
      fails++;
      $display("FAIL defaults_commit: upd=%b ftw=%h wave=%0d, required upd=1 ftw=0 wave=0",
               bus.cfg_update, bus.ftw_out, bus.wave_sel_out);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_ftw();
    test_wave();
    test_bad_chk();
    test_timeout();
    test_timeout_boundary();
    test_garbage();
    test_back_to_back();
    test_reset_mid_frame();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
